// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder shared types and IO map.
// Byte type, default IO window select and IO register offsets.
package mem_io_responder_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [1:0] IO_SEL_DEF  = 2'b11;
  localparam logic [2:0] IO_OFS_DATA = 3'd0;
  localparam logic [2:0] IO_OFS_HALT = 3'd4;

endpackage

// File: rtl/mem_io_responder_if.sv
// mem_io_responder byte-wide CPU memory bus.
// master = CPU memory controller, slave = responder.
interface mem_io_responder_if;
  import mem_io_responder_pkg::*;

  logic [31:0] mem_a;
  byte_t       mem_dout;
  logic        mem_wr;
  byte_t       mem_din;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_dout, mem_wr,
    input  mem_din, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr,
    output mem_din, io_buffer_full
  );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// mem_io_responder circular byte FIFO.
// Push when full and pop when empty are ignored.
module mem_io_responder_byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  byte_t                  din,
  output byte_t                  dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  byte_t          mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rp];

  // Storage array, written at the write pointer.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      count <= count
             + {{AW{1'b0}}, push_ok}
             - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus UART/halt IO window.
// Define IO_STATUS_EN for the status read and TX overflow flag.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int         RAM_AW   = 17,
  parameter int         TX_DEPTH = 8,
  parameter logic [1:0] IO_SEL   = IO_SEL_DEF
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  mem_io_responder_if.slave  bus,
  output byte_t              tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  byte_t              rx_data,
  input  logic               rx_valid,
  output logic               halt
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(TX_DEPTH - 2);

  byte_t           ram [2**RAM_AW];
  byte_t           ram_q;
  byte_t           io_q;
  byte_t           io_rdata;
  byte_t           rx_byte;
  logic            sel_io_q;
  logic            rx_avail;
  logic            io_hit;
  logic            ofs_data;
  logic            ofs_halt;
  logic            wr_ram;
  logic            rd_data;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            unused_hi;

  assign unused_hi = ^bus.mem_a[31:18];

  assign io_hit   = (bus.mem_a[17:16] == IO_SEL);
  assign ofs_data = io_hit
                 && (bus.mem_a[15:0] == {13'd0, IO_OFS_DATA});
  assign ofs_halt = io_hit
                 && (bus.mem_a[15:0] == {13'd0, IO_OFS_HALT});

  assign wr_ram  = rdy_in && bus.mem_wr && !io_hit;
  assign rd_data = rdy_in && !bus.mem_wr && ofs_data;
  assign push    = rdy_in && bus.mem_wr && ofs_data;
  assign pop     = rdy_in && tx_valid && tx_ready;

  assign tx_valid           = !fifo_empty;
  assign bus.io_buffer_full = (count >= FULL_LVL);
  assign bus.mem_din        = sel_io_q ? io_q : ram_q;

  mem_io_responder_byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .push  (push),
    .pop   (pop),
    .din   (bus.mem_dout),
    .dout  (tx_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef IO_STATUS_EN
  logic overflow;

  // Sticky flag for stores dropped on a full FIFO.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)             overflow <= 1'b0;
    else if (push && fifo_full) overflow <= 1'b1;
  end
`else
  logic unused_full;
  assign unused_full = fifo_full;
`endif

  // IO read data for the current address.
  always_comb begin
    io_rdata = '0;
    unique case (1'b1)
      ofs_data: io_rdata = rx_avail ? rx_byte : '0;
`ifdef IO_STATUS_EN
      ofs_halt: io_rdata = {5'b0, overflow,
                            bus.io_buffer_full, rx_avail};
`endif
      default: io_rdata = '0;
    endcase
  end

  // Single-port RAM with registered read port.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (wr_ram) ram[bus.mem_a[RAM_AW-1:0]] <= bus.mem_dout;
      ram_q <= ram[bus.mem_a[RAM_AW-1:0]];
    end
  end

  // IO read register and source select; reset reads as 0.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      io_q     <= '0;
      sel_io_q <= 1'b1;
    end else if (rdy_in) begin
      io_q     <= io_rdata;
      sel_io_q <= io_hit;
    end
  end

  // RX holding byte; a new byte beats a clearing read.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_byte  <= '0;
      rx_avail <= 1'b0;
    end else if (rdy_in) begin
      if (rx_valid) begin
        rx_byte  <= rx_data;
        rx_avail <= 1'b1;
      end else if (rd_data) begin
        rx_avail <= 1'b0;
      end
    end
  end

  // Sticky halt until reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                              halt <= 1'b0;
    else if (rdy_in && bus.mem_wr && ofs_halt) halt <= 1'b1;
  end

endmodule
